alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
- Initiator side of the ALU interface: accepts R-type operation requests over a valid/ready handshake.
- Decodes the 6-bit funct field into the 4-bit ALU control code and drives registered operands and control into the combinational ALU.
- Captures the ALU result and zero flag, then returns them over a valid/ready response channel with backpressure.
- Sits between the instruction-level control path and the ALU; gives MUL a configurable multicycle settle window.

Parameters:
- DATA_W, 32, operand/result width.
- MUL_CYCLES, 2, EXEC cycles granted to MUL (ctrl 3); legal range 1..15.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted this cycle when high together with req_valid_i.
- req_funct_i  input  6  R-type funct field.
- req_src1_i  input  DATA_W  operand 1, signed.
- req_src2_i  input  DATA_W  operand 2, signed.
- alu_src1_o  output  DATA_W  registered operand 1 to ALU.
- alu_src2_o  output  DATA_W  registered operand 2 to ALU.
- alu_ctrl_o  output  4  registered ALU control code.
- alu_result_i  input  DATA_W  ALU result, combinational from alu_* outputs.
- alu_zero_i  input  1  ALU zero flag.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed when high together with rsp_valid_o.
- rsp_result_o  output  DATA_W  captured result.
- rsp_zero_o  output  1  captured zero flag.
- rsp_err_o  output  1  request carried an unsupported funct.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset (next edge with rst_i=1):
  - state=IDLE.
  - req_ready_o=1 (combinational from state).
  - alu_src1_o=0, alu_src2_o=0, alu_ctrl_o=4'd15.
  - rsp_valid_o=0, rsp_result_o=0, rsp_zero_o=0, rsp_err_o=0.
  - Exec counter=0.
- Decode (funct -> ctrl):
  - 0x24 -> 0 (AND)
  - 0x25 -> 1 (OR)
  - 0x20 -> 2 (ADD)
  - 0x18 -> 3 (MUL)
  - 0x22 -> 6 (SUB)
  - 0x2A -> 7 (SLT, signed)
  - 0x27 -> 12 (NOR)
  - Any other funct -> 15, with err flag latched to 1.
- State machine (IDLE, EXEC, RESP):
  - IDLE:
    - req_ready_o=1.
    - On req_valid_i: latch src1/src2 into alu_src*_o, decoded code into alu_ctrl_o, err into an internal flag.
    - Load counter with MUL_CYCLES-1 if code==3, else 0; go to EXEC.
  - EXEC:
    - req_ready_o=0; alu_* outputs held stable.
    - If counter!=0: decrement.
    - If counter==0: capture alu_result_i->rsp_result_o, alu_zero_i->rsp_zero_o, err flag->rsp_err_o; set rsp_valid_o=1; go to RESP.
  - RESP:
    - req_ready_o=0; rsp_* outputs held stable while rsp_valid_o=1 and rsp_ready_i=0.
    - On rsp_ready_i: rsp_valid_o=0; go to IDLE. rsp_result/zero/err keep their last values.
- Latency:
  - Non-MUL: accept at edge N, response valid after edge N+2.
  - MUL: response valid after edge N+1+MUL_CYCLES.
- Throughput:
  - No same-cycle accept in RESP; next accept earliest the cycle after response handshake.
  - Back-to-back non-MUL ops with rsp_ready_i tied high: one per 3 cycles.
- Unsupported funct: still passes through EXEC for 1 cycle with ctrl 15. ALU default gives result 0, so response is result 0, zero 1, err 1.
- Arithmetic: no width change. ALU result is the low DATA_W bits; MUL overflow is truncated by the ALU, not flagged here.
- Boundaries:
  - req_valid_i outside IDLE: ignored; no latch, no ready.
  - Request payload may change freely once accepted.
  - rst_i during EXEC or RESP: transaction dropped, reset values above applied at that edge, no response emitted.
  - rsp_ready_i high while rsp_valid_o=0: no effect.
  - MUL_CYCLES=1: MUL timing identical to non-MUL.

Test Plan:
- Reset then ADD: funct 0x20, src1=5, src2=7, rsp_ready_i=1 -> alu_ctrl_o=2 in EXEC; rsp_valid_o 2 cycles after accept with result 12, zero 0, err 0; req_ready_o high the cycle after.
- SUB to zero plus SLT: funct 0x22, 9-9 -> result 0, zero 1. Then funct 0x2A, src1=-3 (0xFFFFFFFD), src2=2 -> result 1, zero 0.
- MUL latency with MUL_CYCLES=2: funct 0x18, 6*7 -> EXEC held 2 cycles with alu_ctrl_o=3; result 42 valid 3 cycles after accept.
- Backpressure: NOR, src1=0, src2=0, rsp_ready_i low 4 cycles -> rsp_valid_o=1 and result 0xFFFFFFFF stable all 4 cycles; req_ready_o=0; a new req_valid_i is ignored; handshake completes when rsp_ready_i rises.
- Bad funct 0x3F, src1=1, src2=1 -> alu_ctrl_o=15; response result 0, zero 1, err 1. A following valid ADD clears err to 0.
- Reset mid-MUL: assert rst_i in first EXEC cycle -> next cycle state IDLE, rsp_valid_o=0, alu_ctrl_o=15, req_ready_o=1; no response ever appears for the dropped op.

Source files
------------

// File: rtl/alu_op_issuer.sv
// Initiator side of the ALU interface: accepts R-type requests, decodes funct,
// drives registered operands/control to the ALU and returns the captured result.
module alu_op_issuer #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [5:0]        req_funct_i,
  input  logic [DATA_W-1:0] req_src1_i,
  input  logic [DATA_W-1:0] req_src2_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CTRL_MUL = 4'd3;
  localparam logic [3:0] CTRL_BAD = 4'd15;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t     state, next_state;
  logic [3:0] exec_cnt;
  logic       err_q;
  logic [3:0] dec_ctrl;
  logic       dec_err;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_ctrl = CTRL_BAD;
    dec_err  = 1'b0;
    case (req_funct_i)
      6'h24:   dec_ctrl = 4'd0;
      6'h25:   dec_ctrl = 4'd1;
      6'h20:   dec_ctrl = 4'd2;
      6'h18:   dec_ctrl = CTRL_MUL;
      6'h22:   dec_ctrl = 4'd6;
      6'h2A:   dec_ctrl = 4'd7;
      6'h27:   dec_ctrl = 4'd12;
      default: dec_err  = 1'b1;
    endcase
  end

  always_comb begin
    next_state  = state;
    req_ready_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) next_state = EXEC;
      end
      EXEC:    if (exec_cnt == 4'd0) next_state = RESP;
      RESP:    if (rsp_ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_src1_o   <= '0;
      alu_src2_o   <= '0;
      alu_ctrl_o   <= CTRL_BAD;
      err_q        <= 1'b0;
      exec_cnt     <= 4'd0;
      rsp_valid_o  <= 1'b0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          alu_src1_o <= req_src1_i;
          alu_src2_o <= req_src2_i;
          alu_ctrl_o <= dec_ctrl;
          err_q      <= dec_err;
          exec_cnt   <= (dec_ctrl == CTRL_MUL) ? MUL_LOAD : 4'd0;
        end
        EXEC: begin
          if (exec_cnt != 4'd0) begin
            exec_cnt <= exec_cnt - 4'd1;
          end else begin
            rsp_result_o <= alu_result_i;
            rsp_zero_o   <= alu_zero_i;
            rsp_err_o    <= err_q;
            rsp_valid_o  <= 1'b1;
          end
        end
        // Payload registers keep their last values after the handshake.
        RESP: if (rsp_ready_i) rsp_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed self-checking bench for alu_op_issuer with a behavioural ALU attached.
module tb_alu_op_issuer;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [5:0]    req_funct_i = '0;
  logic [DW-1:0] req_src1_i = '0;
  logic [DW-1:0] req_src2_i = '0;
  logic [DW-1:0] alu_src1_o, alu_src2_o;
  logic [3:0]    alu_ctrl_o;
  logic [DW-1:0] alu_result_i;
  logic          alu_zero_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_result_o;
  logic          rsp_zero_o, rsp_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  alu_op_issuer #(.DATA_W(DW), .MUL_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct_i(req_funct_i),
    .req_src1_i(req_src1_i), .req_src2_i(req_src2_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o)
  );

  // Combinational ALU the issuer talks to.
  always_comb begin
    case (alu_ctrl_o)
      4'd0:    alu_result_i = alu_src1_o & alu_src2_o;
      4'd1:    alu_result_i = alu_src1_o | alu_src2_o;
      4'd2:    alu_result_i = alu_src1_o + alu_src2_o;
      4'd3:    alu_result_i = alu_src1_o * alu_src2_o;
      4'd6:    alu_result_i = alu_src1_o - alu_src2_o;
      4'd7:    alu_result_i = ($signed(alu_src1_o) < $signed(alu_src2_o)) ? 32'd1 : 32'd0;
      4'd12:   alu_result_i = ~(alu_src1_o | alu_src2_o);
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  // One full transaction from IDLE with rsp_ready_i high; payload is scrambled after accept.
  task automatic run_op(input string tag, input logic [5:0] funct,
                        input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                        input logic [3:0] exp_ctrl, input int exec_cycles,
                        input logic [DW-1:0] exp_res, input logic exp_zero, input logic exp_err);
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_funct_i = funct; req_src1_i = s1; req_src2_i = s2;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_funct_i = 6'h3F; req_src1_i = 32'hDEAD_BEEF; req_src2_i = 32'h1234_5678;
    for (int i = 0; i < exec_cycles; i++) begin
      n_cmp++;
      if (alu_ctrl_o !== exp_ctrl || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 ||
          alu_src1_o !== s1 || alu_src2_o !== s2) begin
        n_bad++;
        $display("FAIL %s exec[%0d]: ctrl=%0d rdy=%b vld=%b s1=%h s2=%h, want ctrl=%0d rdy=0 vld=0 s1=%h s2=%h",
                 tag, i, alu_ctrl_o, req_ready_o, rsp_valid_o, alu_src1_o, alu_src2_o, exp_ctrl, s1, s2);
      end
      @(negedge clk_i);
    end
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || rsp_result_o !== exp_res || rsp_zero_o !== exp_zero ||
        rsp_err_o !== exp_err || req_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s rsp: vld=%b res=%h zero=%b err=%b rdy=%b, want vld=1 res=%h zero=%b err=%b rdy=0",
               tag, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o, req_ready_o, exp_res, exp_zero, exp_err);
    end
    @(negedge clk_i);
    n_cmp++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s idle: vld=%b rdy=%b, want vld=0 rdy=1", tag, rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (req_ready_o !== 1'b1 || alu_ctrl_o !== 4'd15 || alu_src1_o !== '0 || alu_src2_o !== '0 ||
        rsp_valid_o !== 1'b0 || rsp_result_o !== '0 || rsp_zero_o !== 1'b0 || rsp_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b ctrl=%0d s1=%h s2=%h vld=%b res=%h z=%b e=%b, want 1 15 0 0 0 0 0 0",
               req_ready_o, alu_ctrl_o, alu_src1_o, alu_src2_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_add();
    run_op("add", 6'h20, 32'd5, 32'd7, 4'd2, 1, 32'd12, 1'b0, 1'b0);
  endtask

  task automatic test_logic_ops();
    run_op("sub_zero", 6'h22, 32'd9, 32'd9, 4'd6, 1, 32'd0, 1'b1, 1'b0);
    run_op("slt_neg", 6'h2A, 32'hFFFF_FFFD, 32'd2, 4'd7, 1, 32'd1, 1'b0, 1'b0);
    run_op("and", 6'h24, 32'h0000_F0F0, 32'h0000_FF00, 4'd0, 1, 32'h0000_F000, 1'b0, 1'b0);
    run_op("or", 6'h25, 32'h0000_F0F0, 32'h0000_FF00, 4'd1, 1, 32'h0000_FFF0, 1'b0, 1'b0);
  endtask

  task automatic test_mul();
    run_op("mul", 6'h18, 32'd6, 32'd7, 4'd3, 2, 32'd42, 1'b0, 1'b0);
    run_op("mul_trunc", 6'h18, 32'h0001_0000, 32'h0001_0003, 4'd3, 2, 32'h0003_0000, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_funct_i = 6'h27; req_src1_i = '0; req_src2_i = '0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hFFFF_FFFF || rsp_zero_o !== 1'b0 || req_ready_o !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: vld=%b res=%h zero=%b rdy=%b, want 1 ffffffff 0 0",
                 i, rsp_valid_o, rsp_result_o, rsp_zero_o, req_ready_o);
      end
      req_valid_i = 1'b1; req_funct_i = 6'h20; req_src1_i = 32'h55; req_src2_i = 32'h66;
      @(negedge clk_i);
    end
    n_cmp++;
    if (alu_ctrl_o !== 4'd12 || alu_src1_o !== '0 || rsp_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ignore: ctrl=%0d s1=%h vld=%b, want 12 0 1", alu_ctrl_o, alu_src1_o, rsp_valid_o);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_result_o !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL bp_release: vld=%b rdy=%b res=%h, want 0 1 ffffffff", rsp_valid_o, req_ready_o, rsp_result_o);
    end
  endtask

  task automatic test_bad_funct();
    run_op("bad_funct", 6'h3F, 32'd1, 32'd1, 4'd15, 1, 32'd0, 1'b1, 1'b1);
    run_op("err_clear", 6'h20, 32'd3, 32'd4, 4'd2, 1, 32'd7, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int rsps = 0;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_funct_i = 6'h20; req_src1_i = 32'd1; req_src2_i = 32'd1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready_o === 1'b1) accepts++;
      if (rsp_valid_o === 1'b1 && rsp_result_o === 32'd2) rsps++;
      @(negedge clk_i);
    end
    req_valid_i = 1'b0;
    n_cmp++;
    if (accepts != 3 || rsps != 3) begin
      n_bad++;
      $display("FAIL b2b: accepts=%0d rsps=%0d in 9 cycles, want 3 3", accepts, rsps);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_mul();
    int stray = 0;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_funct_i = 6'h18; req_src1_i = 32'd6; req_src2_i = 32'd7;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_cmp++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || alu_ctrl_o !== 4'd15 || alu_src1_o !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_mul: rdy=%b vld=%b ctrl=%0d s1=%h, want 1 0 15 0",
               req_ready_o, rsp_valid_o, alu_ctrl_o, alu_src1_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_o !== 1'b0) stray++;
      @(negedge clk_i);
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++;
      $display("FAIL rst_no_rsp: %0d cycles with rsp_valid_o, want 0", stray);
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_add();
    test_logic_ops();
    test_mul();
    test_backpressure();
    test_bad_funct();
    test_back_to_back();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
